// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// RV32I instruction-fetch stage with the IF/ID pipeline register. Owns the
// fetch PC (PCF) and drives a ready/valid instruction-memory port. Accepts an
// EX-stage redirect and the hazard unit's StallF/StallD/FlushD.
//
// A one-entry hold buffer captures a fetch that completes while decode is
// stalled. A KILL state lets a wrong-path request that is already on the bus
// finish its handshake; its data is then discarded.
//
// Ports
//   CLK        in   1   clock, all state on rising edge
//   RST        in   1   asynchronous, active-high reset
//   StallF     in   1   do not launch a new fetch
//   StallD     in   1   hold IF/ID register
//   FlushD     in   1   load bubble into IF/ID
//   PCSrcE     in   1   redirect from branch unit
//   PCTargetE  in   32  redirect target (low bits passed through)
//   IMemReq    out  1   fetch request valid
//   IMemAddr   out  32  fetch address
//   IMemReady  in   1   memory completes request this cycle
//   IMemRData  in   32  fetched instruction
//   InstrD     out  32  IF/ID instruction
//   PCD        out  32  IF/ID PC
//   PCPlus4D   out  32  IF/ID PC+4
//   ValidD     out  1   IF/ID holds a real instruction
//   FetchBusy  out  1   request outstanding and not completing this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pcf_q;
    logic [31:0] pcf_d;
    logic [31:0] old_addr_q;
    logic        hold_valid_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_pcp4_q;
    logic        ifid_valid_q;

    logic        accept;
    logic        fetch_ok;
    logic        hold_ok;
    logic [31:0] pcf_plus4;
    logic [31:0] hold_pcp4;

    // Reset gates the request combinationally so the bus is quiet the moment
    // RST rises, even though the FSM resets straight into S_REQ.
    assign IMemReq   = ~RST & ((state_q == S_REQ) | (state_q == S_KILL));
    assign IMemAddr  = (state_q == S_KILL) ? old_addr_q : pcf_q;
    assign FetchBusy = IMemReq & ~IMemReady;
    assign accept    = IMemReq & IMemReady;

    // A completed right-path fetch; a redirect in the same cycle makes it stale.
    assign fetch_ok  = (state_q == S_REQ) & accept & ~PCSrcE;
    // The redirect clears the buffer, so its contents never reach IF/ID then.
    assign hold_ok   = hold_valid_q & ~PCSrcE;

    assign pcf_plus4 = pcf_q + 32'd4;
    assign hold_pcp4 = hold_pc_q + 32'd4;

    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = PCTargetE;
        end else if ((state_q == S_REQ) && accept) begin
            pcf_d = pcf_plus4;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            old_addr_q   <= RESET_PC;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP;
            hold_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_pcp4_q  <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pcf_q <= pcf_d;

            case (state_q)
                S_IDLE: begin
                    if (PCSrcE || !StallF) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (PCSrcE) begin
                        // An un-accepted request cannot be withdrawn; finish it
                        // at the old address and drop the result.
                        if (!accept) begin
                            state_q    <= S_KILL;
                            old_addr_q <= pcf_q;
                        end
                    end else if (accept) begin
                        if (StallD) begin
                            state_q <= S_HOLD;
                        end else if (StallF) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_KILL: begin
                    // A further redirect only moves PCF; the bus stays on old_addr_q.
                    if (!PCSrcE && accept) begin
                        state_q <= StallF ? S_IDLE : S_REQ;
                    end
                end
                S_HOLD: begin
                    if (PCSrcE) begin
                        state_q <= S_REQ;
                    end else if (!StallD) begin
                        state_q <= StallF ? S_IDLE : S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase

            if (PCSrcE) begin
                hold_valid_q <= 1'b0;
            end else if (fetch_ok && StallD) begin
                hold_valid_q <= 1'b1;
                hold_instr_q <= IMemRData;
                hold_pc_q    <= pcf_q;
            end else if ((state_q == S_HOLD) && !StallD) begin
                hold_valid_q <= 1'b0;
            end

            // Flush beats stall; a bubble keeps the PC fields for debug visibility.
            if (FlushD) begin
                ifid_instr_q <= NOP;
                ifid_valid_q <= 1'b0;
            end else if (!StallD) begin
                if (hold_ok) begin
                    ifid_instr_q <= hold_instr_q;
                    ifid_pc_q    <= hold_pc_q;
                    ifid_pcp4_q  <= hold_pcp4;
                    ifid_valid_q <= 1'b1;
                end else if (fetch_ok) begin
                    ifid_instr_q <= IMemRData;
                    ifid_pc_q    <= pcf_q;
                    ifid_pcp4_q  <= pcf_plus4;
                    ifid_valid_q <= 1'b1;
                end else begin
                    ifid_instr_q <= NOP;
                    ifid_valid_q <= 1'b0;
                end
            end
        end
    end

    assign InstrD   = ifid_instr_q;
    assign PCD      = ifid_pc_q;
    assign PCPlus4D = ifid_pcp4_q;
    assign ValidD   = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady = 1'b0;
    logic [31:0] IMemRData = '0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, FetchBusy;

    int vectors = 0;
    int miscompares = 0;

    fetch_stage #(.RESET_PC(RST_PC), .NOP(NOP)) dut (
        .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemReady(IMemReady), .IMemRData(IMemRData), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusy(FetchBusy)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        m_hold[$];     // decoded-stall capture, at most one entry
    logic        m_req;         // a request is on the bus this cycle
    logic [31:0] m_addr;        // its address
    logic        m_dead;        // it belongs to an abandoned path
    logic [31:0] m_pc;          // next sequential fetch address
    logic [31:0] m_instr, m_pcd, m_pcp4;
    logic        m_valid;

    task automatic model_reset();
        m_hold.delete();
        m_req = 1'b1; m_addr = RST_PC; m_dead = 1'b0; m_pc = RST_PC;
        m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit acc, live, had_hold;
        ent_t h;
        if (RST) begin model_reset(); return; end
        acc      = m_req && IMemReady;
        live     = acc && !m_dead && !PCSrcE;
        had_hold = (m_hold.size() > 0);
        if (had_hold) h = m_hold[0];
        if (FlushD) begin
            m_instr = NOP; m_valid = 1'b0;
        end else if (!StallD) begin
            if (had_hold && !PCSrcE) begin
                m_instr = h.instr; m_pcd = h.pc; m_pcp4 = h.pc + 32'd4; m_valid = 1'b1;
            end else if (live) begin
                m_instr = IMemRData; m_pcd = m_addr; m_pcp4 = m_addr + 32'd4; m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end
        end
        if (PCSrcE) m_hold.delete();
        else if (live && StallD) m_hold.push_back('{IMemRData, m_addr});
        else if (had_hold && !StallD) m_hold.delete();
        if (PCSrcE) begin
            m_pc = PCTargetE;
            if (m_req && (m_dead || !acc)) m_dead = 1'b1;
            else begin m_req = 1'b1; m_addr = PCTargetE; m_dead = 1'b0; end
        end else if (m_req && acc) begin
            if (!m_dead) m_pc = m_pc + 32'd4;
            m_dead = 1'b0;
            if (live && StallD) m_req = 1'b0;
            else begin m_req = !StallF; m_addr = m_pc; end
        end else if (!m_req) begin
            if (had_hold) begin
                if (!StallD) begin m_req = !StallF; m_addr = m_pc; end
            end else if (!StallF) begin
                m_req = 1'b1; m_addr = m_pc;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        IMemReady = 0; IMemRData = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        tick();
        RST = 1'b0;
    endtask

    task automatic warm(input int n);
        for (int i = 0; i < n; i++) begin
            IMemReady = 1'b1;
            IMemRData = 32'h1000_0000 + 32'(4 * i);
            #1;
            tick();
        end
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        IMemReady = 1'b1;
        RST = 1'b1;
        model_reset();
        #1;
        vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", IMemReq); end
        vectors++; if (FetchBusy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", FetchBusy); end
        vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", ValidD); end
        vectors++; if (InstrD !== NOP) begin miscompares++; $display("FAIL rst_instr got %h exp %h", InstrD, NOP); end
        vectors++; if (PCD !== 32'h0) begin miscompares++; $display("FAIL rst_pcd got %h exp 0", PCD); end
        vectors++; if (PCPlus4D !== 32'h0) begin miscompares++; $display("FAIL rst_pcp4 got %h exp 0", PCPlus4D); end
        tick();
        RST = 1'b0;
        #1;
        vectors++; if (IMemReq !== 1'b1) begin miscompares++; $display("FAIL rst_rel_req got %b exp 1", IMemReq); end
        vectors++; if (IMemAddr !== RST_PC) begin miscompares++; $display("FAIL rst_rel_addr got %h exp %h", IMemAddr, RST_PC); end
    endtask

    task automatic test_sequential();
        do_reset();
        IMemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IMemRData = 32'hC0DE_0000 + 32'(4 * i);
            #1;
            if (i < 3) begin
                vectors++; if (IMemAddr !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_addr i=%0d got %h exp %h", i, IMemAddr, 32'(4 * i)); end
            end
            if (i > 0) begin
                vectors++; if (PCD !== 32'(4 * (i - 1))) begin miscompares++; $display("FAIL seq_pcd i=%0d got %h exp %h", i, PCD, 32'(4 * (i - 1))); end
                vectors++; if (InstrD !== 32'hC0DE_0000 + 32'(4 * (i - 1))) begin miscompares++; $display("FAIL seq_instr i=%0d got %h", i, InstrD); end
                vectors++; if (ValidD !== 1'b1) begin miscompares++; $display("FAIL seq_valid i=%0d got %b exp 1", i, ValidD); end
                vectors++; if (PCPlus4D !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_pcp4 i=%0d got %h exp %h", i, PCPlus4D, 32'(4 * i)); end
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        warm(2);
        for (int k = 0; k < 3; k++) begin
            IMemReady = 1'b0;
            #1;
            vectors++; if (IMemAddr !== 32'h8) begin miscompares++; $display("FAIL wait_addr k=%0d got %h exp 8", k, IMemAddr); end
            vectors++; if (FetchBusy !== 1'b1) begin miscompares++; $display("FAIL wait_busy k=%0d got %b exp 1", k, FetchBusy); end
            if (k > 0) begin
                vectors++; if (ValidD !== 1'b0 || InstrD !== NOP) begin miscompares++; $display("FAIL wait_bubble k=%0d got v=%b i=%h exp v=0 i=%h", k, ValidD, InstrD, NOP); end
            end
            tick();
        end
        IMemReady = 1'b1;
        IMemRData = 32'h0808_0808;
        #1;
        vectors++; if (FetchBusy !== 1'b0) begin miscompares++; $display("FAIL wait_busy_end got %b exp 0", FetchBusy); end
        tick();
        vectors++; if (PCD !== 32'h8 || InstrD !== 32'h0808_0808 || ValidD !== 1'b1) begin miscompares++; $display("FAIL wait_deliver got pc=%h i=%h v=%b exp pc=8", PCD, InstrD, ValidD); end
        vectors++; if (IMemAddr !== 32'hC) begin miscompares++; $display("FAIL wait_next_addr got %h exp c", IMemAddr); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        warm(4);
        IMemReady = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h100;
        #1;
        vectors++; if (IMemAddr !== 32'h10) begin miscompares++; $display("FAIL redir_addr0 got %h exp 10", IMemAddr); end
        tick();
        PCSrcE = 1'b0;
        #1;
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h10) begin miscompares++; $display("FAIL redir_kill_addr got r=%b a=%h exp r=1 a=10", IMemReq, IMemAddr); end
        tick();
        IMemReady = 1'b1; IMemRData = 32'hDEAD_BEEF;
        #1;
        vectors++; if (IMemAddr !== 32'h10) begin miscompares++; $display("FAIL redir_kill_hold got %h exp 10", IMemAddr); end
        tick();
        IMemRData = 32'h1111_0100;
        #1;
        vectors++; if (IMemAddr !== 32'h100) begin miscompares++; $display("FAIL redir_target got %h exp 100", IMemAddr); end
        vectors++; if (ValidD !== 1'b0 || InstrD !== NOP) begin miscompares++; $display("FAIL redir_drop got v=%b i=%h exp v=0 i=%h", ValidD, InstrD, NOP); end
        tick();
        vectors++; if (PCD !== 32'h100 || InstrD !== 32'h1111_0100 || ValidD !== 1'b1) begin miscompares++; $display("FAIL redir_first got pc=%h i=%h v=%b exp pc=100", PCD, InstrD, ValidD); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        warm(8);
        StallF = 1'b1; StallD = 1'b1; IMemReady = 1'b1; IMemRData = 32'hABCD_0000;
        #1;
        vectors++; if (IMemAddr !== 32'h20) begin miscompares++; $display("FAIL hold_addr got %h exp 20", IMemAddr); end
        tick();
        IMemRData = 32'hFFFF_FFFF;
        #1;
        vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL hold_req got %b exp 0", IMemReq); end
        vectors++; if (PCD !== 32'h1C || InstrD !== 32'h1000_001C) begin miscompares++; $display("FAIL hold_ifid_frozen got pc=%h i=%h exp pc=1c i=1000001c", PCD, InstrD); end
        tick();
        StallF = 1'b0; StallD = 1'b0;
        #1;
        vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL hold_req_rel got %b exp 0", IMemReq); end
        tick();
        vectors++; if (InstrD !== 32'hABCD_0000 || PCD !== 32'h20 || PCPlus4D !== 32'h24 || ValidD !== 1'b1) begin miscompares++; $display("FAIL hold_release got i=%h pc=%h p4=%h v=%b exp abcd0000/20/24/1", InstrD, PCD, PCPlus4D, ValidD); end
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h24) begin miscompares++; $display("FAIL hold_next got r=%b a=%h exp r=1 a=24", IMemReq, IMemAddr); end
    endtask

    task automatic test_flush_redirect_hold();
        do_reset();
        warm(2);
        StallD = 1'b1; IMemReady = 1'b1; IMemRData = 32'h5555_0008;
        #1;
        tick();
        FlushD = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
        #1;
        vectors++; if (IMemReq !== 1'b0) begin miscompares++; $display("FAIL fr_hold_req got %b exp 0", IMemReq); end
        tick();
        FlushD = 1'b0; PCSrcE = 1'b0; StallD = 1'b0; IMemReady = 1'b0;
        #1;
        vectors++; if (ValidD !== 1'b0 || InstrD !== NOP) begin miscompares++; $display("FAIL fr_flush got v=%b i=%h exp v=0 i=%h", ValidD, InstrD, NOP); end
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h200) begin miscompares++; $display("FAIL fr_target got r=%b a=%h exp r=1 a=200", IMemReq, IMemAddr); end
        tick();
        vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL fr_hold_dropped got v=%b i=%h exp v=0", ValidD, InstrD); end
        IMemReady = 1'b1; IMemRData = 32'h2222_0200;
        #1;
        tick();
        vectors++; if (PCD !== 32'h200 || InstrD !== 32'h2222_0200) begin miscompares++; $display("FAIL fr_first got pc=%h i=%h exp pc=200 i=22220200", PCD, InstrD); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        warm(16);
        IMemReady = 1'b0;
        #1;
        vectors++; if (IMemAddr !== 32'h40 || FetchBusy !== 1'b1) begin miscompares++; $display("FAIL mr_pending got a=%h b=%b exp a=40 b=1", IMemAddr, FetchBusy); end
        tick();
        #2;
        RST = 1'b1;
        #1;
        vectors++; if (IMemReq !== 1'b0 || FetchBusy !== 1'b0) begin miscompares++; $display("FAIL mr_req got r=%b b=%b exp 0", IMemReq, FetchBusy); end
        vectors++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin miscompares++; $display("FAIL mr_ifid got v=%b i=%h pc=%h p4=%h", ValidD, InstrD, PCD, PCPlus4D); end
        tick();
        RST = 1'b0; IMemReady = 1'b1;
        #1;
        vectors++; if (IMemReq !== 1'b1 || IMemAddr !== RST_PC) begin miscompares++; $display("FAIL mr_restart got r=%b a=%h exp r=1 a=%h", IMemReq, IMemAddr, RST_PC); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        e_req;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            RST       = ($urandom_range(0, 499) == 0);
            StallF    = ($urandom_range(0, 4) == 0);
            StallD    = ($urandom_range(0, 4) == 0);
            FlushD    = ($urandom_range(0, 9) == 0);
            PCSrcE    = ($urandom_range(0, 9) == 0);
            IMemReady = ($urandom_range(0, 9) < 6);
            IMemRData = $urandom;
            r = $urandom;
            case ($urandom_range(0, 7))
                0:       PCTargetE = 32'hFFFF_FFF8;
                1:       PCTargetE = r;
                default: PCTargetE = r & 32'hFFFF_FFFC;
            endcase
            if (RST) model_reset();
            #1;
            e_req = m_req & ~RST;
            vectors++; if (IMemReq !== e_req) begin miscompares++; $display("FAIL rnd_req c=%0d got %b exp %b", c, IMemReq, e_req); end
            if (e_req) begin
                vectors++; if (IMemAddr !== m_addr) begin miscompares++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, IMemAddr, m_addr); end
            end
            vectors++; if (FetchBusy !== (e_req & ~IMemReady)) begin miscompares++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, FetchBusy, e_req & ~IMemReady); end
            vectors++; if (ValidD !== m_valid) begin miscompares++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, ValidD, m_valid); end
            vectors++; if (InstrD !== m_instr) begin miscompares++; $display("FAIL rnd_instr c=%0d got %h exp %h", c, InstrD, m_instr); end
            vectors++; if (PCD !== m_pcd) begin miscompares++; $display("FAIL rnd_pcd c=%0d got %h exp %h", c, PCD, m_pcd); end
            vectors++; if (PCPlus4D !== m_pcp4) begin miscompares++; $display("FAIL rnd_pcp4 c=%0d got %h exp %h", c, PCPlus4D, m_pcp4); end
            tick();
        end
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_sequential();
        test_wait_states();
        test_redirect_inflight();
        test_stall_hold();
        test_flush_redirect_hold();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
